// File: rtl/fft_ring_launch_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : fft_ring_pkg                                                    |
// | Purpose : Shared types and constants for the FFT ring launch scheduler.   |
// |           te_fft_eng_state - per-engine occupancy state                   |
// |           FFT_PT_RST       - first point number a ring node launches      |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
package fft_ring_pkg;

   typedef enum logic [0:0] {
      ENG_IDLE = 1'b0,
      ENG_BUSY = 1'b1
   } te_fft_eng_state;

   // Ring nodes restart their point counter at 1, so the checker does too.
   localparam logic [31:0] FFT_PT_RST = 32'd1;

endpackage
`default_nettype wire

// File: rtl/fft_ring_launch_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface: fft_ring_launch_sched_if                                       |
// | Purpose  : Bundles the ring-node request side and FFT-engine side of the  |
// |            launch scheduler.                                              |
// | Ports    : req_valid/req_pt (node -> sched), req_ack (sched -> node),     |
// |            eng_start/eng_node/eng_pt/eng_busy (sched -> engines),         |
// |            eng_done (engines -> sched), launch_cnt/err_* status.          |
// | Modports : master = node array + engine pool, slave = scheduler.          |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
interface fft_ring_launch_sched_if #(
   parameter int NNODES = 16,
   parameter int NENG   = 4,
   parameter int NIDW   = $clog2(NNODES)
);
   logic [NNODES-1:0]           req_valid;
   logic [NNODES-1:0][31:0]     req_pt;
   logic [NNODES-1:0]           req_ack;
   logic [NENG-1:0]             eng_start;
   logic [NENG-1:0][NIDW-1:0]   eng_node;
   logic [NENG-1:0][31:0]       eng_pt;
   logic [NENG-1:0]             eng_done;
   logic [NENG-1:0]             eng_busy;
   logic [31:0]                 launch_cnt;
   logic                        err_seq;
   logic                        err_done_idle;

   modport master (
      output req_valid, req_pt, eng_done,
      input  req_ack, eng_start, eng_node, eng_pt, eng_busy,
             launch_cnt, err_seq, err_done_idle
   );

   modport slave (
      input  req_valid, req_pt, eng_done,
      output req_ack, eng_start, eng_node, eng_pt, eng_busy,
             launch_cnt, err_seq, err_done_idle
   );
endinterface
`default_nettype wire

// File: rtl/fft_ring_launch_sched_rr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : fft_rr_arb                                                      |
// | Purpose : Combinational N-way round-robin picker. Selects the first set   |
// |           bit of req at or above ptr, wrapping around.                    |
// | Ports   : req (N), ptr (IW) in; grant one-hot (N), grant_idx (IW),        |
// |           any (1) out.                                                    |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module fft_rr_arb #(
   parameter int N  = 16,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          any
);
   logic [IW-1:0] idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      idx       = '0;
      for (int k = 0; k < N; k++) begin
         idx = IW'((int'(ptr) + k) % N);
         if (!any && req[idx]) begin
            any        = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/fft_ring_launch_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : fft_ring_launch_sched                                           |
// | Purpose : Shares NENG FFT engines among NNODES ring nodes. Grants launch  |
// |           requests round-robin onto the lowest idle engine, tracks engine |
// |           occupancy and checks per-node point-number sequencing.          |
// | Ports   : clk, rst (sync, active-high); bus (slave modport) carrying the  |
// |           request handshake, engine bindings and status flags.           |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module fft_ring_launch_sched
   import fft_ring_pkg::*;
#(
   parameter int NNODES = 16,
   parameter int NENG   = 4,
   parameter int NIDW   = $clog2(NNODES),
   parameter int EIDW   = (NENG > 1) ? $clog2(NENG) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   fft_ring_launch_sched_if.slave bus
);
   te_fft_eng_state             eng_state_q [NENG];
   te_fft_eng_state             eng_state_d [NENG];
   logic [NNODES-1:0]           req_ack_q;
   logic [NENG-1:0]             eng_start_q;
   logic [NENG-1:0][NIDW-1:0]   eng_node_q;
   logic [NENG-1:0][31:0]       eng_pt_q;
   logic [31:0]                 launch_cnt_q;
   logic                        err_seq_q;
   logic                        err_done_idle_q;
   logic [NIDW-1:0]             rr_ptr;
   logic [31:0]                 exp_pt [NNODES];

   logic [NNODES-1:0]           eligible;
   logic [NNODES-1:0]           win_onehot;
   logic [NIDW-1:0]             win_idx;
   logic                        win_any;
   logic [EIDW-1:0]             eng_sel;
   logic                        eng_found;
   logic                        grant;
   logic                        done_idle;
   logic [31:0]                 win_pt;

   // A node acked this cycle may still show its old req_valid; mask it.
   assign eligible = bus.req_valid & ~req_ack_q;

   fft_rr_arb #(.N(NNODES), .IW(NIDW)) u_arb (
      .req       (eligible),
      .ptr       (rr_ptr),
      .grant     (win_onehot),
      .grant_idx (win_idx),
      .any       (win_any)
   );

   // Lowest-index idle engine: scan downward so the lowest hit wins.
   always_comb begin
      eng_found = 1'b0;
      eng_sel   = '0;
      for (int e = NENG - 1; e >= 0; e--) begin
         if (eng_state_q[e] == ENG_IDLE) begin
            eng_found = 1'b1;
            eng_sel   = EIDW'(e);
         end
      end
   end

   assign grant  = win_any && eng_found;
   assign win_pt = bus.req_pt[win_idx];

   // Engine next state. A grant only ever targets an idle engine, so it
   // cannot collide with a completion on the same engine.
   always_comb begin
      done_idle = 1'b0;
      for (int e = 0; e < NENG; e++) begin
         eng_state_d[e] = eng_state_q[e];
         case (eng_state_q[e])
            ENG_IDLE: begin
               if (grant && (eng_sel == EIDW'(e)))
                  eng_state_d[e] = ENG_BUSY;
               if (bus.eng_done[e])
                  done_idle = 1'b1;
            end
            ENG_BUSY: begin
               if (bus.eng_done[e])
                  eng_state_d[e] = ENG_IDLE;
            end
            default: eng_state_d[e] = ENG_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int e = 0; e < NENG; e++) eng_state_q[e] <= ENG_IDLE;
         for (int i = 0; i < NNODES; i++) exp_pt[i] <= FFT_PT_RST;
         req_ack_q       <= '0;
         eng_start_q     <= '0;
         eng_node_q      <= '0;
         eng_pt_q        <= '0;
         launch_cnt_q    <= '0;
         err_seq_q       <= 1'b0;
         err_done_idle_q <= 1'b0;
         rr_ptr          <= '0;
      end else begin
         for (int e = 0; e < NENG; e++) eng_state_q[e] <= eng_state_d[e];
         req_ack_q   <= grant ? win_onehot : '0;
         eng_start_q <= '0;
         if (done_idle)
            err_done_idle_q <= 1'b1;
         if (grant) begin
            eng_start_q[eng_sel] <= 1'b1;
            eng_node_q[eng_sel]  <= win_idx;
            eng_pt_q[eng_sel]    <= win_pt;
            launch_cnt_q         <= launch_cnt_q + 32'd1;
            rr_ptr               <= (win_idx == NIDW'(NNODES - 1)) ? '0 : win_idx + 1'b1;
            if (win_pt != exp_pt[win_idx])
               err_seq_q <= 1'b1;
            // Always resync to the granted point so one slip flags once.
            exp_pt[win_idx] <= win_pt + 32'd1;
         end
      end
   end

   generate
      for (genvar e = 0; e < NENG; e++) begin : g_busy
         assign bus.eng_busy[e] = (eng_state_q[e] == ENG_BUSY);
      end
   endgenerate

   assign bus.req_ack       = req_ack_q;
   assign bus.eng_start     = eng_start_q;
   assign bus.eng_node      = eng_node_q;
   assign bus.eng_pt        = eng_pt_q;
   assign bus.launch_cnt    = launch_cnt_q;
   assign bus.err_seq       = err_seq_q;
   assign bus.err_done_idle = err_done_idle_q;
endmodule
`default_nettype wire

// File: tb/tb_fft_ring_launch_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_fft_ring_launch_sched                                        |
// | Purpose : Randomized scoreboard bench for fft_ring_launch_sched. Inputs   |
// |           change on the falling edge; a reference model predicts the      |
// |           registered outputs and queues expected grants, which a monitor  |
// |           compares one time unit after each rising edge.                  |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module tb_fft_ring_launch_sched;
   import fft_ring_pkg::*;

   localparam int NN = 16;
   localparam int NE = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fft_ring_launch_sched_if #(.NNODES(NN), .NENG(NE)) bus ();

   fft_ring_launch_sched #(.NNODES(NN), .NENG(NE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int          node;
      int          eng;
      int unsigned pt;
   } grant_t;

   // Reference model: what the DUT must show after the next rising edge.
   bit [NN-1:0]  m_ack;
   bit [NE-1:0]  m_start;
   bit [NE-1:0]  m_busy;
   int unsigned  m_cnt;
   bit           m_err_seq;
   bit           m_err_done;
   int           m_rr;
   int unsigned  m_exp [NN];
   grant_t       sb [$];

   // Node-side stimulus state.
   bit           pend [NN];
   int unsigned  pt_next [NN];

   int  checks = 0;
   int  passes = 0;
   bit  mon_en = 1'b0;
   grant_t mon_g;

   task automatic chk(string name, longint unsigned act, longint unsigned exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_step();
      bit [NN-1:0] nack;
      bit [NE-1:0] nstart;
      bit [NE-1:0] nbusy;
      int w;
      int e;
      if (rst) begin
         m_ack = '0; m_start = '0; m_busy = '0; m_cnt = 0;
         m_err_seq = 1'b0; m_err_done = 1'b0; m_rr = 0;
         foreach (m_exp[i]) m_exp[i] = FFT_PT_RST;
         sb.delete();
         return;
      end
      w = -1;
      for (int k = 0; k < NN; k++) begin
         int idx;
         idx = (m_rr + k) % NN;
         if (w < 0 && bus.req_valid[idx] && !m_ack[idx]) w = idx;
      end
      e = -1;
      for (int j = NE - 1; j >= 0; j--) if (!m_busy[j]) e = j;
      nbusy = m_busy;
      for (int j = 0; j < NE; j++) begin
         if (bus.eng_done[j]) begin
            if (m_busy[j]) nbusy[j] = 1'b0;
            else           m_err_done = 1'b1;
         end
      end
      nack = '0;
      nstart = '0;
      if (w >= 0 && e >= 0) begin
         nack[w]   = 1'b1;
         nstart[e] = 1'b1;
         nbusy[e]  = 1'b1;
         m_cnt++;
         m_rr = (w + 1) % NN;
         if (bus.req_pt[w] != m_exp[w]) m_err_seq = 1'b1;
         m_exp[w] = bus.req_pt[w] + 1;
         sb.push_back('{node: w, eng: e, pt: bus.req_pt[w]});
      end
      m_ack = nack;
      m_start = nstart;
      m_busy = nbusy;
   endtask

   // One stimulus cycle: nodes react to the acks visible now, engines
   // complete at random, then the model advances on these inputs.
   task automatic drive_cycle(bit do_rst, int req_pct, int done_pct, int err_pct, int spur_pm);
      @(negedge clk);
      rst = do_rst;
      for (int i = 0; i < NN; i++) begin
         if (do_rst) begin
            pend[i] = 1'b0;
            pt_next[i] = FFT_PT_RST;
         end else begin
            if (m_ack[i]) begin
               pend[i] = 1'b0;
               pt_next[i] = bus.req_pt[i] + 1;
            end
            if (!pend[i] && $urandom_range(99) < req_pct) begin
               pend[i] = 1'b1;
               bus.req_pt[i] = ($urandom_range(99) < err_pct) ? pt_next[i] + 2 : pt_next[i];
            end
         end
         bus.req_valid[i] = pend[i];
      end
      for (int j = 0; j < NE; j++) begin
         if (do_rst)         bus.eng_done[j] = 1'($urandom_range(1));
         else if (m_busy[j]) bus.eng_done[j] = ($urandom_range(99) < done_pct);
         else                bus.eng_done[j] = ($urandom_range(999) < spur_pm);
      end
      model_step();
   endtask

   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         chk("req_ack",       longint'(bus.req_ack),    longint'(m_ack));
         chk("eng_start",     longint'(bus.eng_start),  longint'(m_start));
         chk("eng_busy",      longint'(bus.eng_busy),   longint'(m_busy));
         chk("launch_cnt",    longint'(bus.launch_cnt), longint'(m_cnt));
         chk("err_seq",       longint'(bus.err_seq),    longint'(m_err_seq));
         chk("err_done_idle", longint'(bus.err_done_idle), longint'(m_err_done));
         if (bus.req_ack != '0) begin
            if (sb.size() == 0) begin
               chk("unexpected_grant", longint'(bus.req_ack), 0);
            end else begin
               mon_g = sb.pop_front();
               chk("grant_node_bit", longint'(bus.req_ack), longint'(1) << mon_g.node);
               chk("grant_eng_start", longint'(bus.eng_start[mon_g.eng]), 1);
               chk("grant_eng_node", longint'(bus.eng_node[mon_g.eng]), longint'(mon_g.node));
               chk("grant_eng_pt", longint'(bus.eng_pt[mon_g.eng]), longint'(mon_g.pt));
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      bus.req_valid = '0;
      bus.req_pt = '0;
      bus.eng_done = '0;
      for (int i = 0; i < NN; i++) begin
         pend[i] = 1'b0;
         pt_next[i] = FFT_PT_RST;
      end

      drive_cycle(1'b1, 0, 0, 0, 0);
      mon_en = 1'b1;
      drive_cycle(1'b1, 0, 0, 0, 0);

      // Saturation: every node requests, engines never finish.
      for (int c = 0; c < 20; c++) drive_cycle(1'b0, 100, 0, 0, 0);
      // Engines start finishing; fairness continues from rr pointer.
      for (int c = 0; c < 20; c++) drive_cycle(1'b0, 100, 25, 0, 0);
      // Spurious completions on idle engines with no traffic.
      for (int c = 0; c < 20; c++) drive_cycle(1'b0, 0, 50, 0, 100);

      // Random traffic with sequence errors and occasional resets.
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(299) == 0) begin
            drive_cycle(1'b1, 0, 0, 0, 0);
            drive_cycle(1'b1, 0, 0, 0, 0);
         end else begin
            drive_cycle(1'b0, 30, 20, 5, 10);
         end
      end

      // Reset while all engines are busy, with done pulses during reset.
      for (int c = 0; c < 10; c++) drive_cycle(1'b0, 100, 0, 0, 0);
      drive_cycle(1'b1, 0, 0, 0, 0);
      drive_cycle(1'b1, 0, 0, 0, 0);
      for (int c = 0; c < 30; c++) drive_cycle(1'b0, 40, 20, 10, 0);

      // Drain.
      for (int c = 0; c < 30; c++) drive_cycle(1'b0, 0, 50, 0, 0);
      @(posedge clk);
      #2;
      chk("scoreboard_empty", longint'(sb.size()), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
`default_nettype wire
